// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_GAP
   } state_t;

   localparam int DWELL_DEFAULT = 5000000;
   localparam int GAP_DEFAULT   = 1000;

   // Decoder output with every segment off (segments are active-low).
   localparam logic [6:0] BLANK_CODE = 7'h7F;

endpackage

// File: rtl/seg_disp_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr_i, wrapping.
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic                    gnt_valid_o,
   output logic [$clog2(NREQ)-1:0] gnt_idx_o
);

   localparam int OW = $clog2(NREQ);

   // Scan from farthest to nearest so the nearest set bit is written last and wins.
   always_comb begin
      int idx;
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr_i) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (req_i[idx]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = OW'(idx);
         end
      end
   end

endmodule

// File: rtl/seg_disp_arb.sv
// Round-robin arbiter sharing a two-digit hex display: grant, dwell, acknowledge, blank gap.
module seg_disp_arb
   import seg_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DWELL = DWELL_DEFAULT,
   parameter int GAP   = GAP_DEFAULT
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NREQ-1:0]         req_i,
   input  logic [8*NREQ-1:0]       data_i,
   output logic [NREQ-1:0]         ack_o,
   output logic [3:0]              hex0_o,
   output logic [3:0]              hex1_o,
   output logic                    blank_o,
   output logic [$clog2(NREQ)-1:0] owner_o,
   output logic                    busy_o
);

   localparam int OW      = $clog2(NREQ);
   localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OW-1:0]   ptr_q, ptr_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [3:0]      hex0_q, hex0_d;
   logic [3:0]      hex1_q, hex1_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            blank_q, blank_d;
   logic            busy_q, busy_d;

   logic            gntValid;
   logic [OW-1:0]   gntIdx;
   logic [7:0]      grantByte;

   rr_pick #(.NREQ(NREQ)) picker (
      .req_i       (req_i),
      .ptr_i       (ptr_q),
      .gnt_valid_o (gntValid),
      .gnt_idx_o   (gntIdx)
   );

   always_comb begin
      grantByte = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gntIdx == OW'(i)) begin
            grantByte = data_i[8*i +: 8];
         end
      end
   end

   // Every output is computed one cycle ahead from the next state, so all outputs are registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      hex0_d  = hex0_q;
      hex1_d  = hex1_q;
      ack_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (gntValid) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
               owner_d = gntIdx;
               hex0_d  = grantByte[3:0];
               hex1_d  = grantByte[7:4];
            end
         end
         ST_SHOW: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DWELL_LAST) begin
               ack_d[owner_q] = 1'b1;
               ptr_d          = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
               cnt_d          = '0;
               state_d        = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      blank_d = (state_d != ST_SHOW);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         hex0_q  <= '0;
         hex1_q  <= '0;
         ack_q   <= '0;
         blank_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         hex0_q  <= hex0_d;
         hex1_q  <= hex1_d;
         ack_q   <= ack_d;
         blank_q <= blank_d;
         busy_q  <= busy_d;
      end
   end

   assign ack_o   = ack_q;
   assign hex0_o  = hex0_q;
   assign hex1_o  = hex1_q;
   assign blank_o = blank_q;
   assign owner_o = owner_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_seg_disp_arb.sv
// Scoreboard bench for seg_disp_arb: two configurations (DWELL=5/GAP=2 and DWELL=1/GAP=0) share one stimulus.
module tb_seg_disp_arb;

   localparam int NREQ = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;

   logic [3:0]  ackV   [2];
   logic [3:0]  hex0V  [2];
   logic [3:0]  hex1V  [2];
   logic        blankV [2];
   logic        busyV  [2];
   logic [1:0]  ownerV [2];

   int compared   = 0;
   int mismatched = 0;
   logic doneFlag = 1'b0;

   typedef struct {
      int         cyc;
      int         owner;
      logic [7:0] val;
   } exp_t;

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   for (genvar c = 0; c < 2; c++) begin : cfg
      localparam int D = (c == 0) ? 5 : 1;
      localparam int G = (c == 0) ? 2 : 0;

      exp_t grantQ[$];
      exp_t ackQ[$];
      int   edgeN  = 0;
      int   freeAt = 0;
      int   ptr    = 0;
      exp_t cur;
      bit   haveCur   = 1'b0;
      bit   prevBlank = 1'b1;
      int   runLen    = 0;

      seg_disp_arb #(.NREQ(NREQ), .DWELL(D), .GAP(G)) dut (
         .clk_i   (clk),
         .rst_i   (rst),
         .req_i   (req),
         .data_i  (data),
         .ack_o   (ackV[c]),
         .hex0_o  (hex0V[c]),
         .hex1_o  (hex1V[c]),
         .blank_o (blankV[c]),
         .owner_o (ownerV[c]),
         .busy_o  (busyV[c])
      );

      // Timeline model: a grant at edge g occupies the display until edge g+D+G+1.
      always @(posedge clk) begin : model
         exp_t e;
         int   w;
         edgeN++;
         if (rst) begin
            grantQ.delete();
            ackQ.delete();
            ptr    = 0;
            freeAt = edgeN + 1;
         end else if (edgeN >= freeAt && req != 4'b0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
               if (w < 0 && req[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
            end
            e.cyc   = edgeN;
            e.owner = w;
            e.val   = data[8*w +: 8];
            grantQ.push_back(e);
            e.cyc = edgeN + D;
            ackQ.push_back(e);
            ptr    = (w + 1) % NREQ;
            freeAt = edgeN + D + G + 1;
         end
      end

      always @(negedge clk) begin : monitor
         exp_t e;
         if (blankV[c] === 1'b0) begin
            if (prevBlank) begin
               checkOutput($sformatf("cfg%0d_grant_expected", c), (grantQ.size() > 0) ? 1 : 0, 1);
               haveCur = 1'b0;
               if (grantQ.size() > 0) begin
                  cur     = grantQ.pop_front();
                  haveCur = 1'b1;
                  runLen  = 0;
                  checkOutput($sformatf("cfg%0d_grant_cycle", c), edgeN, cur.cyc);
                  checkOutput($sformatf("cfg%0d_grant_owner", c), ownerV[c], cur.owner);
                  checkOutput($sformatf("cfg%0d_grant_busy", c), busyV[c], 1);
               end
            end
            if (haveCur) begin
               checkOutput($sformatf("cfg%0d_hex0", c), hex0V[c], cur.val[3:0]);
               checkOutput($sformatf("cfg%0d_hex1", c), hex1V[c], cur.val[7:4]);
            end
            runLen++;
         end else if (blankV[c] === 1'b1) begin
            if (!prevBlank && haveCur) begin
               checkOutput($sformatf("cfg%0d_show_len", c), runLen, D);
            end
            haveCur = 1'b0;
         end
         if (ackV[c] != 4'b0) begin
            checkOutput($sformatf("cfg%0d_ack_expected", c), (ackQ.size() > 0) ? 1 : 0, 1);
            if (ackQ.size() > 0) begin
               e = ackQ.pop_front();
               checkOutput($sformatf("cfg%0d_ack_cycle", c), edgeN, e.cyc);
               checkOutput($sformatf("cfg%0d_ack_bits", c), ackV[c], 1 << e.owner);
            end
         end
         prevBlank = (blankV[c] !== 1'b0);
         if (rst) begin
            haveCur   = 1'b0;
            prevBlank = 1'b1;
         end
      end

      always @(posedge doneFlag) begin
         checkOutput($sformatf("cfg%0d_pending_grants", c), grantQ.size(), 0);
         checkOutput($sformatf("cfg%0d_pending_acks", c), ackQ.size(), 0);
      end
   end

   task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [31:0] d, input int n);
      rst  = r;
      req  = rq;
      data = d;
      repeat (n) @(posedge clk);
      if (n > 0) #1;
   endtask

   // Waits until configuration 0 starts showing, then returns one cycle into the dwell.
   task automatic waitShow(input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         if (blankV[0] === 1'b0) seen = 1'b1;
      end
      checkOutput(name, seen, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      logic r;
      applyStimulus(1'b1, 4'b0, 32'h0, 3);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("cfg%0d_reset_blank", i), blankV[i], 1);
         checkOutput($sformatf("cfg%0d_reset_busy", i), busyV[i], 0);
         checkOutput($sformatf("cfg%0d_reset_hex0", i), hex0V[i], 0);
         checkOutput($sformatf("cfg%0d_reset_hex1", i), hex1V[i], 0);
         checkOutput($sformatf("cfg%0d_reset_ack", i), ackV[i], 0);
         checkOutput($sformatf("cfg%0d_reset_owner", i), ownerV[i], 0);
      end

      applyStimulus(1'b0, 4'b0001, 32'h0000_00A5, 1);
      applyStimulus(1'b0, 4'b0000, 32'h0000_00A5, 12);

      applyStimulus(1'b0, 4'b1111, 32'h4433_2211, 40);
      applyStimulus(1'b0, 4'b0000, 32'h4433_2211, 10);

      applyStimulus(1'b0, 4'b0010, 32'h0000_5A00, 0);
      waitShow("data_change_show_seen");
      applyStimulus(1'b0, 4'b0000, 32'h0000_FF00, 12);

      applyStimulus(1'b0, 4'b0001, 32'h0000_00C3, 0);
      waitShow("reset_mid_show_seen");
      applyStimulus(1'b0, 4'b0000, 32'h0000_00C3, 1);
      applyStimulus(1'b1, 4'b0000, 32'h0000_00C3, 1);
      applyStimulus(1'b0, 4'b0110, 32'h0077_6600, 0);
      waitShow("post_reset_show_seen");
      checkOutput("post_reset_owner", ownerV[0], 1);
      applyStimulus(1'b0, 4'b0000, 32'h0077_6600, 12);

      applyStimulus(1'b0, 4'b0011, 32'h0000_B1A0, 12);
      applyStimulus(1'b0, 4'b0000, 32'h0000_B1A0, 10);

      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 99) == 0);
         n = r ? 1 : $urandom_range(1, 4);
         applyStimulus(r, 4'($urandom), $urandom, n);
      end

      applyStimulus(1'b0, 4'b0000, 32'h0, 20);
      doneFlag = 1'b1;
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seg_disp_arb.md
# seg_disp_arb

Round-robin arbiter that shares the two-digit seven-segment display between up to NREQ requesters. Each requester presents a byte (two hex nibbles). The arbiter grants one requester at a time, holds its value on the display for a fixed dwell time, acknowledges it, then blanks for a short gap before serving the next. It sits directly upstream of the hex-to-segment decoder: `hex0`, `hex1` and `blank` drive that decoder, and `blank` forces all segments off.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DWELL`, 5000000: cycles a granted value stays on the display, ≥1.
- `GAP`, 1000: blank cycles after each dwell, ≥0.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  level request; bit i = requester i.
- `data`  in  8*NREQ  requester i byte at [8i+7:8i]; low nibble to `hex0`, high nibble to `hex1`.
- `ack`  out  NREQ  one-cycle pulse on bit of served requester at end of dwell.
- `hex0`  out  4  low digit to decoder.
- `hex1`  out  4  high digit to decoder.
- `blank`  out  1  1 = display off.
- `owner`  out  clog2(NREQ)  index of current/last granted requester.
- `busy`  out  1  1 while in SHOW or GAP.

## Operation
- FSM states: IDLE, SHOW, GAP. All outputs registered.
- **IDLE**
  - `blank`=1, `busy`=0.
  - If any `req` bit is high at a clock edge, pick a winner by round-robin. The search starts at `ptr`, where `ptr` = (last owner + 1) mod NREQ, and takes the first set bit.
  - On that edge, latch `data[winner]` into `hex0`/`hex1`, set `owner`=winner, clear the dwell counter, and go to SHOW.
- **SHOW**
  - `blank`=0, `busy`=1. Counter increments each cycle.
  - In the cycle where counter == DWELL-1:
    - set `ack[owner]`=1 for the next cycle only;
    - go to GAP if GAP>0, else to IDLE;
    - update `ptr` to owner+1 (wrap at NREQ).
- **GAP**
  - `blank`=1, `busy`=1. Counter counts GAP cycles, then the FSM goes to IDLE.
  - `hex0`/`hex1`/`owner` hold their last values.
- Data is snapshotted at grant. Changes on `data` or deassertion of `req` during SHOW/GAP are ignored, and the dwell always completes and is acked.
- `req` is a level. A requester whose `req` is still high in IDLE after its `ack` is treated as a new request, but it has the lowest priority because of the `ptr` rotation.
- Counter width is clog2(max(DWELL,GAP)+1). No wrap is possible, since the counter is cleared on every state entry.
- Reset values: state IDLE, `blank`=1, `busy`=0, `hex0`=`hex1`=0, `ack`=0, `owner`=0, `ptr`=0 (requester 0 has first priority).
- Reset asserted mid-SHOW or mid-GAP: the next cycle shows the full reset values. No `ack` is issued for the aborted grant.

## Timing
- Grant latency: `req` high at edge k while in IDLE → `blank`=0 and valid hex from cycle k+1.
- `blank`=0 for exactly DWELL cycles per grant.
- `ack` is high in the first cycle after SHOW ends, concurrent with the first GAP cycle (or the IDLE cycle when GAP=0).
- `blank`=1 for GAP cycles, plus at least one IDLE cycle, between consecutive grants.
- Minimum period per grant: DWELL+GAP+1 cycles.
- With DWELL=1, SHOW lasts one cycle and `ack` follows in the next cycle.
- Requester i is served within (NREQ-1)·(DWELL+GAP+1) cycles after raising `req`, as long as it holds `req`.

## Structure
- Shared package `seg_pkg`:
  - state enum {IDLE, SHOW, GAP};
  - the `DWELL`/`GAP` defaults;
  - blank-code constant: decoder output all-ones (segments off).
- One sub-module, `rr_pick`, handles round-robin selection:
  - combinational;
  - inputs `req[NREQ]` and `ptr`;
  - outputs `gnt_valid` and `gnt_idx`.
- The seg decoder is not instantiated inside this block. The top level wires `hex0`/`hex1`/`blank` to it.

## Test plan
Unless stated otherwise, use NREQ=4, DWELL=5, GAP=2.
- **Reset:** assert `rst` 3 cycles → `blank`=1, `busy`=0, `hex0`=`hex1`=0, `ack`=0, `owner`=0.
- **Single request:** `req`=0001, `data[7:0]`=8'hA5.
  - Next cycle: `hex0`=5, `hex1`=A, `blank`=0 for 5 cycles.
  - Then `ack`=0001 for one cycle, then `blank`=1 for 2 cycles.
- **Rotation:** `req`=1111 held, distinct data per requester → owners granted in order 0,1,2,3,0, each spaced 8 cycles.
- **Data change and drop:** change `data[15:8]` mid-SHOW and drop `req[1]` mid-SHOW → display keeps the grant-time byte for the full 5 cycles and `ack[1]` still pulses.
- **Reset mid-SHOW:** assert `rst` in SHOW cycle 3 → no `ack`. After reset, `req`=0110 grants owner 1 first.
- **Minimum parameters:** DWELL=1, GAP=0, `req`=0011 held → grants alternate 0,1,0,1. `blank`=0 for one cycle in every two.
